br_resolve_unit: RTL and testbench

- Parametrised branch-resolution block for the EX stage.
- Holds the architectural N/Z/V flag register and evaluates all eight branch conditions against it.
- Compares each outcome with the IF-stage prediction; on a mispredict, issues a registered redirect to IF over a valid/ready handshake and raises a one-cycle flush.
- Keeps saturating taken and mispredict counters for performance tracking.

---
 rtl/br_pkg.sv | 26 ++
 rtl/br_cond_eval.sv | 28 ++
 rtl/br_resolve_unit.sv | 118 +++++++++++
 tb/tb_br_resolve_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared constants for branch resolution: branch opcode, condition codes,
// flag bit positions and the redirect FSM state encoding.
package br_pkg;

  localparam logic [3:0] OP_BR = 4'b1100;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Bit positions inside the packed {N,Z,V} flag vector
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } br_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition evaluator: (br_cond, N, Z, V) -> cond_true.
// Zero latency, no state, no backpressure.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic       flag_n,
  input  logic       flag_z,
  input  logic       flag_v,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      CC_NEQ:    cond_true = ~flag_z;
      CC_EQ:     cond_true = flag_z;
      CC_GT:     cond_true = ~flag_z & ~flag_n;
      CC_LT:     cond_true = flag_n;
      CC_GTE:    cond_true = ~flag_n;
      CC_LTE:    cond_true = flag_n | flag_z;
      CC_OVFL:   cond_true = flag_v;
      CC_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolution: flag register, condition check, mispredict redirect to IF.
// Redirect/flush one cycle after detection; redirect held until redirect_ready, EX stalled meanwhile.
module br_resolve_unit
  import br_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 16,
  parameter int FLAG_FWD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        flag_we,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  input  logic              br_valid,
  input  logic [3:0]        opcode,
  input  logic [2:0]        br_cond,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic              redirect_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              stall,
  output logic [2:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  br_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic              flush_d;
  logic [2:0]        alu_flags;
  logic [2:0]        flags_new;
  logic [2:0]        eff_flags;
  logic              cond_true;
  logic              accepted;
  logic              taken;
  logic              mispredict;

  assign alu_flags = {alu_n, alu_z, alu_v};
  assign flags_new = (flag_we & alu_flags) | (~flag_we & flags_q);
  // Forwarding lets a branch see the flags written by the instruction ahead of it
  assign eff_flags = (FLAG_FWD != 0) ? flags_new : flags_q;

  br_cond_eval u_cond_eval (
    .br_cond   (br_cond),
    .flag_n    (eff_flags[FLAG_N]),
    .flag_z    (eff_flags[FLAG_Z]),
    .flag_v    (eff_flags[FLAG_V]),
    .cond_true (cond_true)
  );

  assign stall          = (state_q == ST_REDIRECT);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign accepted       = br_valid & (opcode == OP_BR) & ~stall;
  assign taken          = accepted & cond_true;
  assign mispredict     = accepted & (cond_true != pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      redirect_pc <= '0;
      flush       <= 1'b0;
    end else begin
      state_q     <= state_d;
      redirect_pc <= pc_d;
      flush       <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = redirect_pc;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d = ST_REDIRECT;
          pc_d    = cond_true ? br_target : pc_plus1;
          flush_d = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      if (taken && (taken_cnt != {CNT_W{1'b1}})) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Runs a forwarding/4-bit-counter instance and a registered-flags/16-bit instance side by side
// on shared stimulus, checking both against a cycle-level reference model.
module tb_br_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  flag_we;
  logic        alu_n, alu_z, alu_v;
  logic        br_valid;
  logic [3:0]  opcode;
  logic [2:0]  br_cond;
  logic        pred_taken;
  logic [15:0] br_target, pc_plus1;
  logic        redirect_ready;

  logic        rv0, fl0, st0, rv1, fl1, st1;
  logic [15:0] rpc0, rpc1;
  logic [2:0]  fq0, fq1;
  logic [3:0]  tc0, mc0;
  logic [15:0] tc1, mc1;

  always #5 clk = ~clk;

  br_resolve_unit #(.ADDR_W(16), .CNT_W(4), .FLAG_FWD(1)) dut_fwd (
    .clk(clk), .rst(rst), .flag_we(flag_we), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .br_valid(br_valid), .opcode(opcode), .br_cond(br_cond), .pred_taken(pred_taken),
    .br_target(br_target), .pc_plus1(pc_plus1), .redirect_ready(redirect_ready),
    .redirect_valid(rv0), .redirect_pc(rpc0), .flush(fl0), .stall(st0), .flags_q(fq0),
    .taken_cnt(tc0), .mispred_cnt(mc0)
  );

  br_resolve_unit #(.ADDR_W(16), .CNT_W(16), .FLAG_FWD(0)) dut_reg (
    .clk(clk), .rst(rst), .flag_we(flag_we), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .br_valid(br_valid), .opcode(opcode), .br_cond(br_cond), .pred_taken(pred_taken),
    .br_target(br_target), .pc_plus1(pc_plus1), .redirect_ready(redirect_ready),
    .redirect_valid(rv1), .redirect_pc(rpc1), .flush(fl1), .stall(st1), .flags_q(fq1),
    .taken_cnt(tc1), .mispred_cnt(mc1)
  );

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = forwarding instance, 1 = registered-flags instance
  bit [2:0] m_flags  [2];
  bit       m_redir  [2];
  int       m_rpc    [2];
  bit       m_flush  [2];
  int       m_taken  [2];
  int       m_mis    [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit cond_fn(input int cc, input bit n, input bit z, input bit v);
    case (cc)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return !n;
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit [2:0] alu, eff, nxt;
      bit acc, c, tk, mp;
      int cmax;
      cmax = (i == 0) ? 15 : 65535;
      if (rst) begin
        m_flags[i] = 3'b000; m_redir[i] = 0; m_rpc[i] = 0;
        m_flush[i] = 0; m_taken[i] = 0; m_mis[i] = 0;
      end else begin
        alu = {alu_n, alu_z, alu_v};
        for (int b = 0; b < 3; b++)
          nxt[b] = flag_we[b] ? alu[b] : m_flags[i][b];
        eff = (i == 0) ? nxt : m_flags[i];
        acc = br_valid && (opcode == 4'd12) && !m_redir[i];
        c   = cond_fn(int'(br_cond), eff[2], eff[1], eff[0]);
        tk  = acc && c;
        mp  = acc && (c != pred_taken);
        m_flags[i] = nxt;
        if (m_redir[i]) begin
          m_flush[i] = 0;
          if (redirect_ready) m_redir[i] = 0;
        end else begin
          m_flush[i] = mp;
          if (mp) begin
            m_redir[i] = 1;
            m_rpc[i]   = c ? int'(br_target) : int'(pc_plus1);
          end
        end
        if (tk && m_taken[i] < cmax) m_taken[i]++;
        if (mp && m_mis[i] < cmax) m_mis[i]++;
      end
    end
  endtask

  task automatic check_all();
    check("fwd_redirect_valid", rv0, m_redir[0]);
    check("fwd_redirect_pc", rpc0, m_rpc[0]);
    check("fwd_flush", fl0, m_flush[0]);
    check("fwd_stall", st0, m_redir[0]);
    check("fwd_flags_q", fq0, m_flags[0]);
    check("fwd_taken_cnt", tc0, m_taken[0]);
    check("fwd_mispred_cnt", mc0, m_mis[0]);
    check("reg_redirect_valid", rv1, m_redir[1]);
    check("reg_redirect_pc", rpc1, m_rpc[1]);
    check("reg_flush", fl1, m_flush[1]);
    check("reg_stall", st1, m_redir[1]);
    check("reg_flags_q", fq1, m_flags[1]);
    check("reg_taken_cnt", tc1, m_taken[1]);
    check("reg_mispred_cnt", mc1, m_mis[1]);
  endtask

  // Inputs are driven at negedge; the model advances with the posedge, outputs checked at next negedge
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_in();
    rst = 0; flag_we = 3'b000; alu_n = 0; alu_z = 0; alu_v = 0;
    br_valid = 0; opcode = 4'h0; br_cond = 3'd0; pred_taken = 0;
    br_target = 16'h0; pc_plus1 = 16'h0; redirect_ready = 0;
  endtask

  task automatic write_flags(input bit [2:0] f);
    idle_in();
    flag_we = 3'b111; {alu_n, alu_z, alu_v} = f;
    redirect_ready = 1;
  endtask

  task automatic branch(input bit [2:0] cc, input bit pred, input bit [15:0] tgt, input bit [15:0] pc1);
    idle_in();
    br_valid = 1; opcode = 4'b1100; br_cond = cc; pred_taken = pred;
    br_target = tgt; pc_plus1 = pc1;
  endtask

  initial begin
    idle_in();
    rst = 1;
    @(negedge clk);
    step();
    step();

    // Eq branch on Z=1 predicted not-taken
    write_flags(3'b010); step();
    branch(3'd1, 0, 16'h0040, 16'h0011); step();
    check("tp1_rpc", rpc0, 16'h0040);
    check("tp1_flush", fl1, 1'b1);
    check("tp1_mis", mc1, 16'd1);
    idle_in(); redirect_ready = 1; step();

    // Same-cycle Z write: forwarding sees it, registered path does not
    write_flags(3'b000); step();
    branch(3'd1, 1, 16'h0100, 16'h0051);
    flag_we = 3'b010; alu_z = 1;
    step();
    check("fwd_no_redirect", rv0, 1'b0);
    check("reg_redirect_pc1", rpc1, 16'h0051);
    idle_in(); redirect_ready = 1; step();

    // Redirect held for three cycles with a pending branch on the inputs
    branch(3'd7, 0, 16'h0200, 16'h0021); step();
    for (int k = 0; k < 3; k++) begin
      branch(3'd7, 0, 16'h0300, 16'h0031); step();
    end
    branch(3'd7, 0, 16'h0300, 16'h0031); redirect_ready = 1; step();
    branch(3'd7, 0, 16'h0300, 16'h0031); step();
    check("held_branch_rpc", rpc1, 16'h0300);
    idle_in(); redirect_ready = 1; step();

    // Full condition x flag sweep, predicted not-taken
    for (int cc = 0; cc < 8; cc++) begin
      for (int f = 0; f < 8; f++) begin
        bit [2:0] fb;
        fb = 3'(f);
        write_flags(fb); step();
        branch(3'(cc), 0, 16'(16'h1000 + cc * 8 + f), 16'h0abc); step();
        check($sformatf("sweep_cc%0d_f%0d", cc, f), rv1, cond_fn(cc, fb[2], fb[1], fb[0]));
      end
    end
    idle_in(); redirect_ready = 1; step();

    // Counter saturation from a fresh reset
    idle_in(); rst = 1; step();
    for (int k = 0; k < 20; k++) begin
      branch(3'd7, 1, 16'h0400, 16'h0401); step();
    end
    check("taken_sat4", tc0, 4'hF);
    check("taken_nosat16", tc1, 16'd20);

    // Reset while a redirect is pending
    write_flags(3'b111); step();
    branch(3'd0, 1, 16'h0500, 16'h0501); step();
    idle_in(); step();
    idle_in(); rst = 1; step();
    check("rst_rv", rv0, 1'b0);
    check("rst_stall", st1, 1'b0);
    check("rst_flags", fq0, 3'b000);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      idle_in();
      rst            = ($urandom_range(0, 59) == 0);
      flag_we        = 3'($urandom);
      {alu_n, alu_z, alu_v} = 3'($urandom);
      br_valid       = ($urandom_range(0, 3) != 0);
      opcode         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1100;
      br_cond        = 3'($urandom);
      pred_taken     = 1'($urandom);
      br_target      = 16'($urandom);
      pc_plus1       = 16'($urandom);
      redirect_ready = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
